// File: rtl/spinner_pkg.sv
// Shared encodings for the segment-bank busy animator: mode codes, active-low segment
// constants, per-mode position tables and the sequence-length helper.
package spinner_pkg;

    // Wide-ring mode needs 2*8+4 = 20 positions at the largest bank, so one bit beyond a nibble.
    localparam int POS_W = 5;

    typedef enum logic [1:0] {
        MODE_RING  = 2'd0,
        MODE_FIG8  = 2'd1,
        MODE_WIDE  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_A   = 7'b0111111;
    localparam logic [6:0] SEG_B   = 7'b1011111;
    localparam logic [6:0] SEG_C   = 7'b1101111;
    localparam logic [6:0] SEG_D   = 7'b1110111;
    localparam logic [6:0] SEG_E   = 7'b1111011;
    localparam logic [6:0] SEG_F   = 7'b1111101;
    localparam logic [6:0] SEG_G   = 7'b1111110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] ring_seg(input logic [POS_W-1:0] p);
        case (p)
            5'd0:    return SEG_A;
            5'd1:    return SEG_B;
            5'd2:    return SEG_C;
            5'd3:    return SEG_D;
            5'd4:    return SEG_E;
            5'd5:    return SEG_F;
            default: return SEG_OFF;
        endcase
    endfunction

    function automatic logic [6:0] fig8_seg(input logic [POS_W-1:0] p);
        case (p)
            5'd0:    return SEG_A;
            5'd1:    return SEG_B;
            5'd2:    return SEG_G;
            5'd3:    return SEG_E;
            5'd4:    return SEG_D;
            5'd5:    return SEG_C;
            5'd6:    return SEG_G;
            5'd7:    return SEG_F;
            default: return SEG_OFF;
        endcase
    endfunction

    function automatic logic [POS_W-1:0] seq_len(input mode_e m, input int n);
        case (m)
            MODE_RING: return POS_W'(6);
            MODE_FIG8: return POS_W'(8);
            MODE_WIDE: return POS_W'(2 * n + 4);
            default:   return POS_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/spinner_prescaler.sv
// Step-rate divider: ticks once every div+1 cycles while run is high; holds its count when run is low.
// Comparison is >= so lowering div mid-count produces a tick on the next cycle instead of a long wrap.
module spinner_prescaler #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] pcnt;

    assign tick = run && !clear && (pcnt >= div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (clear || tick) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= pcnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spinner_seq.sv
// Busy-indicator animator stepping a lit segment across a NUM_DIGITS 7-segment bank (active-low seg).
// Define SPINNER_TRAIL_EN to also light the previous position as a comet tail.
module spinner_seq
    import spinner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    dir,
    input  logic [1:0]              mode,
    input  logic [DIV_WIDTH-1:0]    div,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    step,
    output logic                    lap
);

    localparam int SEG_W = 7 * NUM_DIGITS;

    mode_e            mode_cur;
    mode_e            mode_q;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nxt;
    logic [POS_W-1:0] len;
    logic             tick;
    logic             restart;
    logic             at_end;
    logic             wrap;
    logic             advance;

    assign mode_cur = mode_e'(mode);
    assign restart  = clear || (mode_cur != mode_q);
    assign len      = seq_len(mode_cur, NUM_DIGITS);
    assign at_end   = (pos >= len - POS_W'(1));
    assign advance  = tick && (mode_cur != MODE_BLANK);

    spinner_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (restart),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        pos_nxt = pos;
        wrap    = 1'b0;
        if (!dir) begin
            wrap    = at_end;
            pos_nxt = at_end ? '0 : pos + POS_W'(1);
        end else begin
            wrap    = (pos == '0);
            pos_nxt = (pos == '0) ? len - POS_W'(1) : pos - POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos    <= '0;
            mode_q <= MODE_RING;
            step   <= 1'b0;
            lap    <= 1'b0;
        end else begin
            mode_q <= mode_cur;
            step   <= 1'b0;
            lap    <= 1'b0;
            if (restart) begin
                pos <= '0;
            end else if (advance) begin
                pos  <= pos_nxt;
                step <= 1'b1;
                lap  <= wrap;
            end
        end
    end

    // Wide ring walks a across the top (left to right), down the right edge, d back along
    // the bottom, then up the left edge; digit 0 is the rightmost.
    function automatic logic [SEG_W-1:0] decode(input mode_e m, input logic [POS_W-1:0] p);
        logic [SEG_W-1:0] s;
        logic [6:0]       d;
        int               pi;
        s  = '1;
        pi = int'(p);
        case (m)
            MODE_RING: s = {NUM_DIGITS{ring_seg(p)}};
            MODE_FIG8: s = {NUM_DIGITS{fig8_seg(p)}};
            MODE_WIDE: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    d = SEG_OFF;
                    if (pi < NUM_DIGITS && pi == NUM_DIGITS - 1 - k)             d = SEG_A;
                    else if (k == 0 && pi == NUM_DIGITS)                         d = SEG_B;
                    else if (k == 0 && pi == NUM_DIGITS + 1)                     d = SEG_C;
                    else if (pi == NUM_DIGITS + 2 + k)                           d = SEG_D;
                    else if (k == NUM_DIGITS - 1 && pi == 2 * NUM_DIGITS + 2)    d = SEG_E;
                    else if (k == NUM_DIGITS - 1 && pi == 2 * NUM_DIGITS + 3)    d = SEG_F;
                    s[7*k +: 7] = d;
                end
            end
            default: s = '1;
        endcase
        return s;
    endfunction

`ifdef SPINNER_TRAIL_EN
    logic [POS_W-1:0] pos_prev;

    always_comb begin
        pos_prev = pos;
        if (!dir) begin
            pos_prev = (pos == '0) ? len - POS_W'(1) : pos - POS_W'(1);
        end else begin
            pos_prev = at_end ? '0 : pos + POS_W'(1);
        end
    end

    // Active-low, so AND merges the two lit patterns; a shared g collapses to one segment.
    assign seg = decode(mode_cur, pos) & decode(mode_cur, pos_prev);
`else
    assign seg = decode(mode_cur, pos);
`endif

endmodule

// File: tb/tb_spinner_seq.sv
// Directed bench for spinner_seq (NUM_DIGITS=4): reset, ring/figure-eight/wide sequences,
// prescaler re-programming and freeze, clear/mode-change priority and blank mode.
module tb_spinner_seq;

    localparam logic [6:0] A   = 7'b0111111;
    localparam logic [6:0] B   = 7'b1011111;
    localparam logic [6:0] C   = 7'b1101111;
    localparam logic [6:0] D   = 7'b1110111;
    localparam logic [6:0] E   = 7'b1111011;
    localparam logic [6:0] F   = 7'b1111101;
    localparam logic [6:0] G   = 7'b1111110;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk;
    logic        reset;
    logic        run;
    logic        clear;
    logic        dir;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [27:0] seg;
    logic        step;
    logic        lap;

    int checks = 0;
    int errors = 0;
    int nsteps;

    logic [6:0] ring_exp [6];
    logic [6:0] fig8_exp [8];

    spinner_seq #(
        .NUM_DIGITS (4),
        .DIV_WIDTH  (24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (clear),
        .dir   (dir),
        .mode  (mode),
        .div   (div),
        .seg   (seg),
        .step  (step),
        .lap   (lap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ring_exp = '{B, C, D, E, F, A};
        fig8_exp = '{A, B, G, E, D, C, G, F};

        reset = 1'b0; run = 1'b0; clear = 1'b0; dir = 1'b0; mode = 2'd0; div = 24'd0;
        #2;
        chk("rst_seg", seg, {4{A}});
        chk("rst_step", step, 1'b0);
        chk("rst_lap", lap, 1'b0);

        // Run at full rate, then pull reset mid-cycle.
        #10 reset = 1'b1; run = 1'b1;
        cyc(3);
        #3 reset = 1'b0;
        #1;
        chk("midrst_seg", seg, {4{A}});
        chk("midrst_step", step, 1'b0);
        chk("midrst_lap", lap, 1'b0);

        div = 24'd3;
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(3);
            chk("ring_idle", step, 1'b0);
            cyc(1);
            chk("ring_step", step, 1'b1);
            chk("ring_seg", seg, {4{ring_exp[i]}});
            chk("ring_lap", lap, (i == 5));
        end

        mode = 2'd1; div = 24'd0;
        cyc(1);
        chk("fig8_chg_step", step, 1'b0);
        chk("fig8_pos0", seg, {4{A}});
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("fig8_step", step, 1'b1);
            chk("fig8_seg", seg, {4{fig8_exp[i % 8]}});
            chk("fig8_lap", lap, (i == 8));
        end

        mode = 2'd2;
        cyc(1);
        chk("wide_pos0", seg, {A, OFF, OFF, OFF});
        cyc(4);
        chk("wide_pos4", seg, {OFF, OFF, OFF, B});
        chk("wide_pos4_step", step, 1'b1);
        chk("wide_pos4_lap", lap, 1'b0);
        clear = 1'b1;
        cyc(1);
        chk("clr_step", step, 1'b0);
        chk("clr_lap", lap, 1'b0);
        chk("clr_seg", seg, {A, OFF, OFF, OFF});
        clear = 1'b0; dir = 1'b1;
        cyc(1);
        chk("rev_pos11", seg, {F, OFF, OFF, OFF});
        chk("rev_step", step, 1'b1);
        chk("rev_lap", lap, 1'b1);
        cyc(1);
        chk("rev_pos10", seg, {E, OFF, OFF, OFF});
        chk("rev_lap2", lap, 1'b0);

        // Slow divider, then shrink it while the count is past the new limit.
        dir = 1'b0; mode = 2'd0; div = 24'd100;
        cyc(1);
        cyc(50);
        chk("div100_idle", step, 1'b0);
        chk("div100_seg", seg, {4{A}});
        div = 24'd10;
        cyc(1);
        chk("divlow_step", step, 1'b1);
        chk("divlow_seg", seg, {4{B}});
        div = 24'd5;
        cyc(3);
        chk("div5_idle", step, 1'b0);
        run = 1'b0;
        nsteps = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step) nsteps++;
        end
        chk("freeze_steps", nsteps, 0);
        chk("freeze_seg", seg, {4{B}});
        run = 1'b1;
        cyc(2);
        chk("resume_idle", step, 1'b0);
        cyc(1);
        chk("resume_step", step, 1'b1);
        chk("resume_seg", seg, {4{C}});

        div = 24'd0;
        cyc(1);
        chk("pos3_seg", seg, {4{D}});
        mode = 2'd2;
        cyc(1);
        chk("mchg_seg", seg, {A, OFF, OFF, OFF});
        chk("mchg_step", step, 1'b0);
        chk("mchg_lap", lap, 1'b0);

        mode = 2'd3;
        #1;
        chk("blank_now", seg, 28'hFFFFFFF);
        cyc(2);
        chk("blank_seg", seg, 28'hFFFFFFF);
        chk("blank_step", step, 1'b0);

        mode = 2'd0;
        cyc(1);
        cyc(2);
`ifdef SPINNER_TRAIL_EN
        chk("trail_pos2", seg, {4{7'b1001111}});
`else
        chk("single_pos2", seg, {4{C}});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
